// File: rtl/minmax_pkg.sv
// Shared definitions for the window min/max stage: data width, default window
// length and the FSM state type.
package minmax_pkg;

  localparam int unsigned DATA_W         = 4;
  localparam int unsigned DEFAULT_WINDOW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/window_minmax_cmp.sv
// 4-bit unsigned magnitude comparator; exactly one of the three flags is high.
module Comparator4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       A_lt_B,
  output logic       A_gt_B,
  output logic       A_eq_B
);

  assign A_lt_B = (A < B);
  assign A_gt_B = (A > B);
  assign A_eq_B = (A == B);

endmodule

// File: rtl/window_minmax.sv
// Accumulates WINDOW samples, then presents {max, min, all_equal} on an output
// valid/ready handshake. All ordering decisions come from Comparator4bit.
module window_minmax
  import minmax_pkg::*;
#(
  parameter int unsigned WINDOW = DEFAULT_WINDOW,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_max,
  output logic [DATA_W-1:0] out_min,
  output logic              out_all_eq
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   run_max_q, run_max_d;
  logic [DATA_W-1:0]   run_min_q, run_min_d;
  logic                run_eq_q, run_eq_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_max_q, out_max_d;
  logic [DATA_W-1:0]   out_min_q, out_min_d;
  logic                out_all_eq_q, out_all_eq_d;

  logic                max_lt, max_gt, max_eq;
  logic                min_lt, min_gt, min_eq;
  logic                accept;
  logic                last_sample;
  logic [DATA_W-1:0]   upd_max, upd_min;
  logic                upd_eq;

  Comparator4bit u_cmp_max (
    .A      (in_data),
    .B      (run_max_q),
    .A_lt_B (max_lt),
    .A_gt_B (max_gt),
    .A_eq_B (max_eq)
  );

  Comparator4bit u_cmp_min (
    .A      (in_data),
    .B      (run_min_q),
    .A_lt_B (min_lt),
    .A_gt_B (min_gt),
    .A_eq_B (min_eq)
  );

  // rst gates in_ready so no sample can be taken while reset is held
  assign in_ready    = ~rst & (state_q != HOLD) & ~clear;
  assign accept      = in_valid & in_ready;
  assign last_sample = (count_q == CNT_W'(WINDOW - 1));

  // Running values including the sample currently on in_data
  always_comb begin
    upd_max = run_max_q;
    upd_min = run_min_q;
    upd_eq  = run_eq_q;
    case ({max_gt, max_eq, max_lt})
      3'b100: begin
        upd_max = in_data;
        upd_eq  = 1'b0;
      end
      3'b001:  upd_eq = 1'b0;
      default: ;
    endcase
    case ({min_gt, min_eq, min_lt})
      3'b001:  upd_min = in_data;
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    run_max_d    = run_max_q;
    run_min_d    = run_min_q;
    run_eq_d     = run_eq_q;
    out_valid_d  = out_valid_q;
    out_max_d    = out_max_q;
    out_min_d    = out_min_q;
    out_all_eq_d = out_all_eq_q;

    if (clear) begin
      state_d     = IDLE;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            run_max_d = in_data;
            run_min_d = in_data;
            run_eq_d  = 1'b1;
            count_d   = CNT_W'(1);
            state_d   = ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            run_max_d = upd_max;
            run_min_d = upd_min;
            run_eq_d  = upd_eq;
            if (last_sample) begin
              out_max_d    = upd_max;
              out_min_d    = upd_min;
              out_all_eq_d = upd_eq;
              out_valid_d  = 1'b1;
              count_d      = '0;
              state_d      = HOLD;
            end else begin
              count_d = count_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: begin
          state_d     = IDLE;
          count_d     = '0;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      run_max_q    <= '0;
      run_min_q    <= '0;
      run_eq_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_max_q    <= '0;
      out_min_q    <= '0;
      out_all_eq_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      run_max_q    <= run_max_d;
      run_min_q    <= run_min_d;
      run_eq_q     <= run_eq_d;
      out_valid_q  <= out_valid_d;
      out_max_q    <= out_max_d;
      out_min_q    <= out_min_d;
      out_all_eq_q <= out_all_eq_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_max    = out_max_q;
  assign out_min    = out_min_q;
  assign out_all_eq = out_all_eq_q;

endmodule
